// File: rtl/divider_pkg.sv
// Shared CPU defines used by the divider: FSM encoding, iteration count,
// result width and the ALU control codes that select DIV/DIVU.
package divider_pkg;

   localparam int DATA_W   = 32;
   localparam int RESULT_W = 64;
   localparam int DIV_ITER = 32;
   localparam int CNT_W    = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BYZERO = 2'b01,
      ON     = 2'b10,
      END    = 2'b11
   } div_state_t;

   localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
   localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

endpackage

// File: rtl/divider_div_step.sv
// One restoring shift-subtract step: trial-subtract the divisor from the
// already-shifted 33-bit partial remainder and keep it only if it fits.
module div_step
   import divider_pkg::*;
(
   input  logic [DATA_W:0]   pr,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] pr_nxt,
   output logic              qbit
);

   logic [DATA_W-1:0] diff;

   // When the subtraction succeeds the difference is below the divisor, so
   // 32-bit modular arithmetic gives the exact value.
   always_comb begin
      qbit   = (pr >= {1'b0, divisor});
      diff   = pr[DATA_W-1:0] - divisor;
      pr_nxt = qbit ? diff : pr[DATA_W-1:0];
   end

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider (DIV/DIVU): 32 iterations on magnitudes,
// sign correction on completion, HI = remainder, LO = quotient.
module divider
   import divider_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                signed_div,
   input  logic [DATA_W-1:0]   opdata1,
   input  logic [DATA_W-1:0]   opdata2,
   input  logic                annul,
   output logic [RESULT_W-1:0] result,
   output logic                ready,
   output logic                busy,
   output logic                div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

   div_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, quo, dvs;
   logic              sgn_q, sgn_r;
   logic [DATA_W-1:0] rem_nxt;
   logic              qbit;

   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                 input logic              sgn);
      return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                  input logic              neg);
      return neg ? (~x + 1'b1) : x;
   endfunction

   // quo starts as the dividend magnitude; its MSB feeds the remainder each
   // step while quotient bits shift in at the bottom.
   div_step u_div_step (
      .pr      ({1'b0, rem, quo[DATA_W-1]}),
      .divisor (dvs),
      .pr_nxt  (rem_nxt),
      .qbit    (qbit)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !annul)
               state_nxt = (opdata2 == '0) ? BYZERO : ON;
         end
         BYZERO: state_nxt = annul ? IDLE : END;
         ON: begin
            if (annul)
               state_nxt = IDLE;
            else if (cnt == LAST_ITER)
               state_nxt = END;
         end
         END:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start && !annul && (opdata2 != '0)) begin
                  quo   <= abs_val(opdata1, signed_div);
                  dvs   <= abs_val(opdata2, signed_div);
                  rem   <= '0;
                  sgn_q <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                  sgn_r <= signed_div & opdata1[DATA_W-1];
                  cnt   <= '0;
               end
            end
            BYZERO: begin
               if (!annul) begin
                  result      <= '0;
                  div_by_zero <= 1'b1;
               end
            end
            ON: begin
               if (!annul) begin
                  rem <= rem_nxt;
                  quo <= {quo[DATA_W-2:0], qbit};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_ITER) begin
                     result      <= {cond_neg(rem_nxt, sgn_r),
                                     cond_neg({quo[DATA_W-2:0], qbit}, sgn_q)};
                     div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready = (state == END);
   assign busy  = (state == BYZERO) || (state == ON);

endmodule
